// File: rtl/keylock_pkg.sv
// Shared keylock definitions: command key codes, symbol width and the
// entry-state encoding used by code_entry_engine.
package keylock_pkg;

  localparam int SYM_W = 4;

  localparam logic [SYM_W-1:0] KEY_LOCK  = 4'd9;
  localparam logic [SYM_W-1:0] KEY_REPRO = 4'd8;
  localparam logic [SYM_W-1:0] KEY_ABORT = 4'd7;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    OVF     = 2'd2
  } entry_state_e;

  // Keys 7, 8 and 9 are commands; every other value is a code symbol.
  function automatic logic is_cmd_key(input logic [SYM_W-1:0] key);
    return (key == KEY_LOCK) || (key == KEY_REPRO) || (key == KEY_ABORT);
  endfunction

endpackage

// File: rtl/code_compare.sv
// Masked nibble comparator: equal when the entry holds exactly ref_len
// symbols and the low ref_len nibbles of the buffer equal the reference.
module code_compare
  import keylock_pkg::*;
#(
  parameter int MAX_DIGITS = 8
) (
  input  logic [MAX_DIGITS*SYM_W-1:0] code_buf,
  input  logic [MAX_DIGITS*SYM_W-1:0] code_ref,
  input  logic [3:0]                  ref_len,
  input  logic [3:0]                  count,
  output logic                        eq
);

  logic [MAX_DIGITS*SYM_W-1:0] mask;

  // Build a nibble mask covering the low ref_len symbols and compare under it.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < int'(ref_len)) mask[i*SYM_W +: SYM_W] = {SYM_W{1'b1}};
    end
    eq = (count == ref_len) && ((code_buf & mask) == (code_ref & mask));
  end

endmodule

// File: rtl/code_entry_engine.sv
// Keypad code datapath: shift-buffer entry FSM (EMPTY/COLLECT/OVF), reference
// select (passcode > pending UC > active UC), pending-UC capture and commit.
// Optional feature macro: CODE_ENTRY_TIMEOUT_EN enables the idle timeout that
// discards a partial entry after TIMEOUT_CYCLES idle cycles.
module code_entry_engine
  import keylock_pkg::*;
#(
  parameter int                          MAX_DIGITS     = 8,
  parameter int                          MIN_UC_DIGITS  = 4,
  parameter int                          PC_LEN         = 6,
  parameter logic [PC_LEN*SYM_W-1:0]     PASSCODE       = 24'h123456,
  parameter logic [MAX_DIGITS*SYM_W-1:0] DEFAULT_UC     = 32'h00001111,
  parameter int                          DEFAULT_UC_LEN = 4,
  parameter int                          TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       rdy,
  input  logic [3:0] keypress,
  input  logic       CheckPC,
  input  logic       CheckValidUC,
  input  logic       confirmUC,
  input  logic       LOCKING,
  input  logic       Chillin,
  output logic       match,
  output logic       ValidUC,
  output logic [3:0] digit_count,
  output logic       overflow
);

  localparam int         W       = MAX_DIGITS * SYM_W;
  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);
  localparam logic [3:0] MIN_CNT = 4'(MIN_UC_DIGITS);
  localparam logic [W-1:0] PC_REF = W'(PASSCODE);

  entry_state_e   state_q, state_d;
  logic [W-1:0]   code_buf_q, code_buf_d;
  logic [3:0]     count_q, count_d;
  logic [W-1:0]   pending_q, pending_d, active_q, active_d;
  logic [3:0]     pending_len_q, pending_len_d, active_len_q, active_len_d;
  logic           chillin_q;
  logic           timeout_hit;

  logic           sym_strobe, cmd_strobe;
  logic [W-1:0]   ref_sel;
  logic [3:0]     ref_len_sel;
  logic           ref_any;
  logic           eq;

  assign sym_strobe = rdy && !is_cmd_key(keypress);
  assign cmd_strobe = rdy &&  is_cmd_key(keypress);

`ifdef CODE_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q, tmo_d;

  assign timeout_hit = (state_q != EMPTY) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle counter: runs only while an entry is in progress, restarts on any key.
  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (rdy || state_q == EMPTY || timeout_hit) tmo_d = '0;
  end

  // Idle counter register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Entry FSM next state, pending capture and active commit.
  always_comb begin
    state_d       = state_q;
    code_buf_d    = code_buf_q;
    count_d       = count_q;
    pending_d     = pending_q;
    pending_len_d = pending_len_q;
    active_d      = active_q;
    active_len_d  = active_len_q;

    if (cmd_strobe || (!rdy && timeout_hit)) begin
      state_d    = EMPTY;
      code_buf_d = '0;
      count_d    = '0;
    end else if (sym_strobe) begin
      code_buf_d = {code_buf_q[W-SYM_W-1:0], keypress};
      if (state_q == OVF || count_q == MAX_CNT) begin
        state_d = OVF;
        count_d = MAX_CNT;
      end else begin
        state_d = COLLECT;
        count_d = count_q + 4'd1;
      end
    end

    // Capture sees the buffer as it was before the command key clears it.
    if (rdy && keypress == KEY_REPRO && CheckValidUC && ValidUC) begin
      pending_d     = code_buf_q;
      pending_len_d = count_q;
    end

    // Commit on the first Chillin cycle; uses the pre-capture pending value.
    if (Chillin && !chillin_q) begin
      active_d     = pending_q;
      active_len_d = pending_len_q;
    end
  end

  // All entry, UC and edge-detect state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= EMPTY;
      code_buf_q    <= '0;
      count_q       <= '0;
      pending_q     <= DEFAULT_UC;
      pending_len_q <= 4'(DEFAULT_UC_LEN);
      active_q      <= DEFAULT_UC;
      active_len_q  <= 4'(DEFAULT_UC_LEN);
      chillin_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_buf_q    <= code_buf_d;
      count_q       <= count_d;
      pending_q     <= pending_d;
      pending_len_q <= pending_len_d;
      active_q      <= active_d;
      active_len_q  <= active_len_d;
      chillin_q     <= Chillin;
    end
  end

  // Reference select in priority order passcode > pending UC > active UC.
  always_comb begin
    ref_sel     = '0;
    ref_len_sel = '0;
    ref_any     = 1'b1;
    if (CheckPC) begin
      ref_sel     = PC_REF;
      ref_len_sel = 4'(PC_LEN);
    end else if (confirmUC) begin
      ref_sel     = pending_q;
      ref_len_sel = pending_len_q;
    end else if (LOCKING) begin
      ref_sel     = active_q;
      ref_len_sel = active_len_q;
    end else begin
      ref_any = 1'b0;
    end
  end

  code_compare #(.MAX_DIGITS(MAX_DIGITS)) u_cmp (
    .code_buf (code_buf_q),
    .code_ref (ref_sel),
    .ref_len  (ref_len_sel),
    .count    (count_q),
    .eq       (eq)
  );

  assign match       = ref_any && (state_q != OVF) && eq;
  assign ValidUC     = (state_q != OVF) && (count_q >= MIN_CNT) && (count_q <= MAX_CNT);
  assign digit_count = count_q;
  assign overflow    = (state_q == OVF);

endmodule
